// File: rtl/pb_note_encoder.sv
// Push-button front end: synchronizes and debounces 15 raw buttons, encodes the
// highest held note key (with a one-cycle strobe on new notes) and steps a
// three-state synth mode on each press of the mode button.
module pb_note_encoder #(
  parameter int unsigned DB_TICK = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] pb,
  output logic        note_valid,
  output logic [3:0]  note_idx,
  output logic        note_strobe,
  output logic [1:0]  mode
);

  localparam int unsigned NB    = 15;
  localparam int unsigned NKEY  = 14;
  localparam int unsigned CNT_W = (DB_TICK > 2) ? $clog2(DB_TICK) : 1;
  localparam int unsigned MODE_BIT = 14;

  typedef enum logic [1:0] {
    M0 = 2'b00,
    M1 = 2'b01,
    M2 = 2'b10,
    M3 = 2'b11
  } mode_e;

  logic [NB-1:0]    sync1_q, sync2_q;
  logic [NB-1:0]    samp_q, db_q, db_d;
  logic [NB-1:0]    stable_c;
  logic [CNT_W-1:0] cnt_q;
  logic             tick_c;
  logic             valid_q, valid_d;
  logic [3:0]       idx_q, idx_d;
  logic             strobe_q, strobe_d;
  logic             mode_btn_q;
  logic             mode_rise_c;
  mode_e            mode_q;

  // Two-flop synchronizer for every raw button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pb;
      sync2_q <= sync1_q;
    end
  end

  // Sample-period counter; tick marks the last count of each period.
  assign tick_c = (cnt_q == CNT_W'(DB_TICK - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // A bit is accepted only when two consecutive samples agree; otherwise it holds.
  assign stable_c = ~(sync2_q ^ samp_q);
  assign db_d     = (sync2_q & stable_c) | (db_q & ~stable_c);

  // Sample and debounced registers advance once per tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q <= '0;
      db_q   <= '0;
    end else if (tick_c) begin
      samp_q <= sync2_q;
      db_q   <= db_d;
    end
  end

  // Priority encoder over note keys: highest-numbered held key wins.
  always_comb begin
    valid_d = 1'b0;
    idx_d   = 4'd0;
    for (int i = 0; i < int'(NKEY); i++) begin
      if (db_q[i]) begin
        valid_d = 1'b1;
        idx_d   = 4'(i);
      end
    end
  end

  // New note: valid rises, or stays high with a different winner.
  assign strobe_d = valid_d & (~valid_q | (idx_d != idx_q));

  // Registered note outputs and strobe, all updated on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      idx_q    <= 4'd0;
      strobe_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
    end
  end

  // Rising edge of the debounced mode button; cleared on reset so a held
  // button counts as a fresh press afterwards.
  assign mode_rise_c = db_q[MODE_BIT] & ~mode_btn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_btn_q <= 1'b0;
    end else begin
      mode_btn_q <= db_q[MODE_BIT];
    end
  end

  // Mode FSM: M0 -> M1 -> M2 -> M0 on each press; the unused code recovers to M0.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= M0;
    end else begin
      case (mode_q)
        M0:      if (mode_rise_c) mode_q <= M1;
        M1:      if (mode_rise_c) mode_q <= M2;
        M2:      if (mode_rise_c) mode_q <= M0;
        default: mode_q <= M0;
      endcase
    end
  end

  assign note_valid  = valid_q;
  assign note_idx    = idx_q;
  assign note_strobe = strobe_q;
  assign mode        = mode_q;

endmodule
